// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller:
// tuse/pc_sel codes, exception vector, FSM encoding and the per-source hazard test.
package hazard_flush_ctrl_pkg;

    localparam logic [1:0]  TUSE_NONE  = 2'd3;
    localparam logic [1:0]  PC_SEL_SEQ = 2'b00;
    localparam logic [1:0]  PC_SEL_EXC = 2'b01;
    localparam logic [1:0]  PC_SEL_EPC = 2'b10;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam int          MD_CNT_W   = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // A source register hazards when a younger-stage producer will not have its
    // value forwardable by the time the D-stage instruction needs it.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] a3_e,
        input logic [1:0] tnew_e,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m
    );
        return (src != 5'd0) &&
               (((src == a3_e) && (tnew_e > tuse)) ||
                ((src == a3_m) && (tnew_m > tuse)));
    endfunction

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// Datapath <-> sequencing controller signal bundle.
// The datapath (master) supplies stage fields; the controller (slave) returns stall/clear/redirect.
interface hazard_flush_ctrl_if;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic [4:0] A3_E;
    logic [1:0] tnew_E;
    logic [4:0] A3_M;
    logic [1:0] tnew_M;
    logic       md_use_D;
    logic       md_start_E;
    logic       md_is_div_E;
    logic       exc_req_M;
    logic       eret_M;
    logic       stall;
    logic       clr_FD;
    logic       clr_DE;
    logic       clr_EM;
    logic       clr_MW;
    logic [1:0] pc_sel;
    logic       md_busy;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, A3_E, tnew_E, A3_M, tnew_M,
               md_use_D, md_start_E, md_is_div_E, exc_req_M, eret_M,
        input  stall, clr_FD, clr_DE, clr_EM, clr_MW, pc_sel, md_busy
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, A3_E, tnew_E, A3_M, tnew_M,
               md_use_D, md_start_E, md_is_div_E, exc_req_M, eret_M,
        output stall, clr_FD, clr_DE, clr_EM, clr_MW, pc_sel, md_busy
    );
endinterface

// File: rtl/hazard_flush_ctrl_md_busy_counter.sv
// Occupancy counter for the multi-cycle mult/div unit: loads the op latency on
// issue, counts down to zero, and reports busy while non-zero.
module md_busy_counter
    import hazard_flush_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic is_div,
    output logic busy
);

    logic [MD_CNT_W-1:0] md_cnt_q;
    logic [MD_CNT_W-1:0] md_cnt_d;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (load) begin
            md_cnt_d = is_div ? MD_CNT_W'(DIV_LAT) : MD_CNT_W'(MULT_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign busy = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline sequencing controller: load-use and mult/div stalls, exception entry
// and eret redirect with a one-cycle flush window.
module hazard_flush_ctrl
    import hazard_flush_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_flush_ctrl_if.slave   bus
);

    state_e     state_q;
    state_e     state_d;
    logic       haz_rs;
    logic       haz_rt;
    logic       md_haz;
    logic       md_busy;
    logic       md_load;
    logic       stall_c;
    logic       clr_FD_c;
    logic       clr_DE_c;
    logic       clr_EM_c;
    logic       clr_MW_c;
    logic [1:0] pc_sel_c;

    assign haz_rs = src_hazard(bus.rs_D, bus.tuse_rs_D, bus.A3_E, bus.tnew_E, bus.A3_M, bus.tnew_M);
    assign haz_rt = src_hazard(bus.rt_D, bus.tuse_rt_D, bus.A3_E, bus.tnew_E, bus.A3_M, bus.tnew_M);
    assign md_haz = bus.md_use_D & (md_busy | bus.md_start_E);

    // Exception outranks eret, which outranks an ordinary stall; FLUSH ignores
    // M-stage requests because only bubbles occupy M during that cycle.
    always_comb begin
        state_d  = state_q;
        stall_c  = 1'b0;
        clr_FD_c = 1'b0;
        clr_DE_c = 1'b0;
        clr_EM_c = 1'b0;
        clr_MW_c = 1'b0;
        pc_sel_c = PC_SEL_SEQ;
        if (!reset) begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.exc_req_M) begin
                        clr_FD_c = 1'b1;
                        clr_DE_c = 1'b1;
                        clr_EM_c = 1'b1;
                        clr_MW_c = 1'b1;
                        pc_sel_c = PC_SEL_EXC;
                        state_d  = ST_FLUSH;
                    end else if (bus.eret_M) begin
                        clr_FD_c = 1'b1;
                        clr_DE_c = 1'b1;
                        clr_EM_c = 1'b1;
                        pc_sel_c = PC_SEL_EPC;
                        state_d  = ST_FLUSH;
                    end else if (haz_rs | haz_rt | md_haz) begin
                        stall_c  = 1'b1;
                        clr_DE_c = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A mult/div in E that is being flushed never reaches the unit.
    assign md_load = bus.md_start_E & ~clr_EM_c;

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .load   (md_load),
        .is_div (bus.md_is_div_E),
        .busy   (md_busy)
    );

    assign bus.stall   = stall_c;
    assign bus.clr_FD  = clr_FD_c;
    assign bus.clr_DE  = clr_DE_c;
    assign bus.clr_EM  = clr_EM_c;
    assign bus.clr_MW  = clr_MW_c;
    assign bus.pc_sel  = pc_sel_c;
    assign bus.md_busy = md_busy & ~reset;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the controller.
module tb_hazard_flush_ctrl;
    import hazard_flush_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    // Behavioural model state: flush window pending, mult/div cycles remaining.
    bit   m_flush;
    int   m_md;

    hazard_flush_ctrl_if bus ();

    hazard_flush_ctrl #(
        .MULT_LAT (5),
        .DIV_LAT  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Observed outputs packed as {stall, clr_FD, clr_DE, clr_EM, clr_MW, pc_sel[1:0], md_busy}.
    function automatic logic [7:0] get_obs();
        return {bus.stall, bus.clr_FD, bus.clr_DE, bus.clr_EM, bus.clr_MW, bus.pc_sel, bus.md_busy};
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] urs, input logic [1:0] urt,
                         input logic [4:0] ae, input logic [1:0] ne,
                         input logic [4:0] am, input logic [1:0] nm,
                         input logic mu, input logic ms, input logic mdiv,
                         input logic exc, input logic er);
        bus.rs_D = rs;  bus.rt_D = rt;
        bus.tuse_rs_D = urs;  bus.tuse_rt_D = urt;
        bus.A3_E = ae;  bus.tnew_E = ne;
        bus.A3_M = am;  bus.tnew_M = nm;
        bus.md_use_D = mu;  bus.md_start_E = ms;  bus.md_is_div_E = mdiv;
        bus.exc_req_M = exc;  bus.eret_M = er;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic bit model_src_haz(input int src, input int tuse);
        return (src != 0) &&
               ((src == int'(bus.A3_E) && int'(bus.tnew_E) > tuse) ||
                (src == int'(bus.A3_M) && int'(bus.tnew_M) > tuse));
    endfunction

    function automatic logic [7:0] model_out();
        bit busy;
        bit hz;
        if (reset) return 8'h00;
        busy = (m_md > 0);
        hz = model_src_haz(int'(bus.rs_D), int'(bus.tuse_rs_D)) ||
             model_src_haz(int'(bus.rt_D), int'(bus.tuse_rt_D)) ||
             (bus.md_use_D && (busy || bus.md_start_E));
        if (!m_flush && bus.exc_req_M) return {1'b0, 4'b1111, PC_SEL_EXC, busy};
        if (!m_flush && bus.eret_M)    return {1'b0, 4'b1110, PC_SEL_EPC, busy};
        if (!m_flush && hz)            return {1'b1, 4'b0100, PC_SEL_SEQ, busy};
        return {1'b0, 4'b0000, PC_SEL_SEQ, busy};
    endfunction

    task automatic model_step();
        bit redirect;
        if (reset) begin
            m_flush = 1'b0;
            m_md    = 0;
        end else begin
            redirect = !m_flush && (bus.exc_req_M || bus.eret_M);
            if (bus.md_start_E && !redirect) m_md = bus.md_is_div_E ? 10 : 5;
            else if (m_md > 0)               m_md = m_md - 1;
            m_flush = redirect;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (get_obs() !== 8'h00) begin
                fails++;
                $display("FAIL reset_outputs cyc %0d: got %b want %b", i, get_obs(), 8'h00);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_data_hazard();
        logic [7:0] exp_v [6] = '{8'hA0, 8'h00, 8'h00, 8'hA0, 8'h00, 8'hA0};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(5'd1, 5'd0, 2'd1, TUSE_NONE, 5'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                1: drive(5'd1, 5'd0, 2'd1, TUSE_NONE, 5'd1, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                2: drive(5'd0, 5'd0, 2'd0, TUSE_NONE, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                3: drive(5'd0, 5'd5, TUSE_NONE, 2'd0, 5'd0, 2'd0, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                4: drive(5'd0, 5'd5, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 5'd5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                default: drive(5'd7, 5'd9, 2'd2, 2'd0, 5'd7, 2'd3, 5'd9, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            endcase
            @(negedge clk);
            checks++;
            if (get_obs() !== exp_v[i]) begin
                fails++;
                $display("FAIL data_hazard step %0d: got %b want %b", i, get_obs(), exp_v[i]);
            end
            @(posedge clk); #1;
        end
        idle();
    endtask

    task automatic test_md_busy();
        logic [7:0] want;
        int busy_cycles = 0;
        // div issue, then mflo waiting in D until the unit frees up
        drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 11; k++) begin
            if (k == 1) drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            want = (k >= 1 && k <= 10) ? 8'hA1 : 8'h00;
            @(negedge clk);
            checks++;
            if (get_obs() !== want) begin
                fails++;
                $display("FAIL div_busy cyc %0d: got %b want %b", k, get_obs(), want);
            end
            @(posedge clk); #1;
        end
        // mult issued while a mult/div user sits in D: stall that cycle, then 5 busy cycles
        drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (get_obs() !== 8'hA0) begin
            fails++;
            $display("FAIL mult_issue_stall: got %b want %b", get_obs(), 8'hA0);
        end
        @(posedge clk); #1;
        idle();
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (bus.md_busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
        end
        checks++;
        if (busy_cycles != 5) begin
            fails++;
            $display("FAIL mult_busy_len: got %0d want %0d", busy_cycles, 5);
        end
    endtask

    task automatic test_exception();
        logic [7:0] exp_v [5] = '{8'h7A, 8'h00, 8'h7A, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            case (i)
                // exception with a pending load-use hazard and a mult issuing in E
                0: drive(5'd1, 5'd0, 2'd0, TUSE_NONE, 5'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
                1: drive(5'd1, 5'd0, 2'd0, TUSE_NONE, 5'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                2: drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                default: idle();
            endcase
            @(negedge clk);
            checks++;
            if (get_obs() !== exp_v[i]) begin
                fails++;
                $display("FAIL exception step %0d: got %b want %b", i, get_obs(), exp_v[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_eret();
        logic [7:0] exp_v [6] = '{8'h74, 8'h00, 8'h00, 8'h7A, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0, 1: drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                3:    drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                default: idle();
            endcase
            @(negedge clk);
            checks++;
            if (get_obs() !== exp_v[i]) begin
                fails++;
                $display("FAIL eret step %0d: got %b want %b", i, get_obs(), exp_v[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        // mult issue, 2 busy cycles, exception on busy cycle 3, reset on cycle 4 (in FLUSH)
        logic [7:0] exp_v [8] = '{8'h00, 8'h01, 8'h01, 8'h7B, 8'h00, 8'h00, 8'h7A, 8'h00};
        for (int i = 0; i < 8; i++) begin
            reset = 1'b0;
            case (i)
                0: drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                3: drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                4: begin
                    drive(5'd2, 5'd0, 2'd0, TUSE_NONE, 5'd2, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
                    reset = 1'b1;
                end
                6: drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                default: idle();
            endcase
            @(negedge clk);
            checks++;
            if (get_obs() !== exp_v[i]) begin
                fails++;
                $display("FAIL reset_mid step %0d: got %b want %b", i, get_obs(), exp_v[i]);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] want;
        reset = 1'b1;
        idle();
        m_flush = 1'b0;
        m_md    = 0;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) begin
                reset = ($urandom_range(0, 49) == 0);
                drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 11) == 0),
                      1'($urandom_range(0, 11) == 0));
            end
            @(negedge clk);
            want = model_out();
            checks++;
            if (get_obs() !== want) begin
                fails++;
                $display("FAIL random cyc %0d: got %b want %b", i, get_obs(), want);
            end
            @(posedge clk);
            model_step();
            #1;
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        @(posedge clk); #1;
        test_reset();
        test_data_hazard();
        test_md_busy();
        test_exception();
        test_eret();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
